exec_result_arbiter: RTL and testbench
======================================

Name: exec_result_arbiter

Overview:
- Consumer side of the execute-stage completion handshake (valid_o / canGo_i) used by every issue/execute unit (ALU, mult, div).
- Collects completed results from NUM_UNITS execution units and grants exactly one per cycle, round-robin.
- Registers the granted result into a single-entry common-data-bus (CDB) output stage feeding the ROB and reservation stations, with backpressure from the ROB.

Parameters:
- NUM_UNITS, 4, number of execution units arbitrated (>=2).
- ROBsize, 32, ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- unitValid_i  in  NUM_UNITS  per-unit result-valid (unit's valid_o).
- unitVal_i  in  NUM_UNITSx64  per-unit result value.
- unitCommands_i  in  NUM_UNITSx10  per-unit command bits.
- unitTag_i  in  NUM_UNITSxROBsizeLog  per-unit ROB tag.
- unitFlags_i  in  NUM_UNITSx4  per-unit flags.
- canGo_o  out  NUM_UNITS  one-hot grant (unit's canGo_i).
- cdbStall_i  in  1  ROB cannot take a broadcast this cycle.
- cdbValid_o  out  1  CDB entry valid.
- cdbVal_o  out  64  broadcast value.
- cdbCommands_o  out  10  broadcast commands.
- cdbTag_o  out  ROBsizeLog  broadcast tag.
- cdbFlags_o  out  4  broadcast flags.
- cdbSrc_o  out  $clog2(NUM_UNITS)  index of the unit that produced the entry.

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - cdbValid_o=0; all cdb data outputs and cdbSrc_o = 0.
  - Round-robin pointer = 0.
  - canGo_o=0 while reset_i is high.
- Output stage: one register entry.
  - accept = ~cdbValid_o | ~cdbStall_i (empty, or draining this cycle).
- Grant (combinational, same cycle):
  - canGo_o is zero unless accept=1 and at least one unitValid_i bit is set.
  - Otherwise exactly one bit is set: the first requester at or after the pointer, wrapping modulo NUM_UNITS.
  - canGo_o is never set for a unit whose unitValid_i is 0.
  - Units drop valid the cycle after canGo is seen; arbiter must not depend on that.
- On posedge with a grant to unit k:
  - Capture unit k's val/commands/tag/flags into cdb outputs; cdbSrc_o=k; cdbValid_o=1.
  - Pointer = (k+1) mod NUM_UNITS.
- On posedge without a grant:
  - If cdbValid_o & ~cdbStall_i: cdbValid_o=0, data held.
  - Else all state held.
- Latency: unit valid to cdbValid_o is 1 cycle when uncontended and unstalled.
  - Back-to-back broadcasts possible every cycle (drain and refill in the same cycle).
- Stall: while cdbValid_o & cdbStall_i, the entry is stable and canGo_o=0.
- Fairness: with all units continuously valid and no stall, grants cycle 0,1,...,N-1,0. Max wait is NUM_UNITS-1 grants.
- Pointer does not move in cycles with no grant.
- Flags pass through unmodified. No arithmetic on data.

Optional Feature:
- Macro EXEC_ARB_FLUSH_EN.
- Defined: adds input flush_i (1 bit, mispredict flush).
  - When flush_i=1: canGo_o=0 that cycle; at the posedge cdbValid_o is cleared; pointer is held.
  - flush_i has priority over a simultaneous grant or drain.
- Undefined: no flush_i port; behaviour as above.

Decomposition:
- Package exec_arb_pkg:
  - cdb_entry_t packed struct {val[63:0], commands[9:0], tag, flags[3:0]}; tag width taken from the package ROB constants.
  - Default NUM_UNITS constant.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], enable, advance. Outputs: one-hot grant[N], grant index.
  - Owns the round-robin pointer (async reset to 0).
- Top level holds the output register and the accept logic.

Test Plan:
- Single request: unitValid_i=0100, val=0x1234, tag=5, no stall -> canGo_o=0100 same cycle; next cycle cdbValid_o=1, cdbVal_o=0x1234, cdbTag_o=5, cdbSrc_o=2; pointer=3.
- All four valid continuously, no stall -> canGo_o sequence 0001,0010,0100,1000,0001; cdbSrc_o 0,1,2,3,0 on consecutive cycles.
- Stall: cdb holds tag=7, cdbStall_i=1 for 3 cycles while unit1 valid -> canGo_o=0 and tag=7 stable for 3 cycles; stall drops -> canGo_o=0010 the same cycle; unit1's result on the CDB next cycle.
- Pointer wrap: pointer=3, unitValid_i=1001 -> grant 1000; next cycle (unit3 still valid) grant 0001.
- Async reset asserted mid-cycle with cdbValid_o=1 -> cdbValid_o=0 immediately, before any clock edge; after release, unitValid_i=1111 -> first grant 0001.
- With EXEC_ARB_FLUSH_EN: flush_i=1 with cdbValid_o=1 and unitValid_i=0010 -> canGo_o=0; next cycle cdbValid_o=0; following cycle grant 0010.

Source files
------------

// File: rtl/exec_arb_pkg.sv
// rtl/exec_arb_pkg.sv - shared CDB entry type and ROB/arbiter constants
package exec_arb_pkg;

  localparam int NUM_UNITS_DEF = 4;
  localparam int ROB_SIZE      = 32;
  localparam int ROB_SIZE_LOG  = $clog2(ROB_SIZE + 1);

  typedef struct packed {
    logic [63:0]             val;
    logic [9:0]              commands;
    logic [ROB_SIZE_LOG-1:0] tag;
    logic [3:0]              flags;
  } cdb_entry_t;

endpackage

// File: rtl/exec_result_arbiter_rr_arbiter.sv
// rtl/exec_result_arbiter_rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
    if (!enable) begin
      grant = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/exec_result_arbiter.sv
// rtl/exec_result_arbiter.sv - round-robin execute-result arbiter with single-entry CDB output stage
// Optional mispredict flush input enabled by EXEC_ARB_FLUSH_EN.
module exec_result_arbiter
  import exec_arb_pkg::*;
#(
  parameter int NUM_UNITS  = NUM_UNITS_DEF,
  parameter int ROBsize    = ROB_SIZE,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int IW         = $clog2(NUM_UNITS)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
`ifdef EXEC_ARB_FLUSH_EN
  input  logic                            flush_i,
`endif
  input  logic [NUM_UNITS-1:0]            unitValid_i,
  input  logic [NUM_UNITS*64-1:0]         unitVal_i,
  input  logic [NUM_UNITS*10-1:0]         unitCommands_i,
  input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
  input  logic [NUM_UNITS*4-1:0]          unitFlags_i,
  output logic [NUM_UNITS-1:0]            canGo_o,
  input  logic                            cdbStall_i,
  output logic                            cdbValid_o,
  output logic [63:0]                     cdbVal_o,
  output logic [9:0]                      cdbCommands_o,
  output logic [ROBsizeLog-1:0]           cdbTag_o,
  output logic [3:0]                      cdbFlags_o,
  output logic [IW-1:0]                   cdbSrc_o
);

  cdb_entry_t     entry_q, entry_d;
  logic           valid_q, valid_d;
  logic [IW-1:0]  src_q, src_d;
  logic           accept;
  logic           enable;
  logic           any_gnt;
  logic [IW-1:0]  gnt_idx;
  logic           flush;

`ifdef EXEC_ARB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // The entry can be refilled when empty or when it drains this same cycle.
  assign accept  = ~valid_q | ~cdbStall_i;
  assign enable  = accept & ~reset_i & ~flush;
  assign any_gnt = |canGo_o;

  rr_arbiter #(.N(NUM_UNITS), .IW(IW)) u_rr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req       (unitValid_i),
    .enable    (enable),
    .advance   (any_gnt),
    .grant     (canGo_o),
    .grant_idx (gnt_idx)
  );

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    src_d   = src_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (any_gnt) begin
      entry_d.val      = unitVal_i[int'(gnt_idx)*64 +: 64];
      entry_d.commands = unitCommands_i[int'(gnt_idx)*10 +: 10];
      entry_d.tag      = unitTag_i[int'(gnt_idx)*ROBsizeLog +: ROBsizeLog];
      entry_d.flags    = unitFlags_i[int'(gnt_idx)*4 +: 4];
      src_d            = gnt_idx;
      valid_d          = 1'b1;
    end else if (valid_q && !cdbStall_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      entry_q <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  end

  assign cdbValid_o    = valid_q;
  assign cdbVal_o      = entry_q.val;
  assign cdbCommands_o = entry_q.commands;
  assign cdbTag_o      = entry_q.tag;
  assign cdbFlags_o    = entry_q.flags;
  assign cdbSrc_o      = src_q;

endmodule

// File: tb/tb_exec_result_arbiter.sv
// tb/tb_exec_result_arbiter.sv - directed scoreboard bench for exec_result_arbiter
module tb_exec_result_arbiter;

  localparam int NU = 4;
  localparam int TW = 6;

  logic            clk = 1'b0;
  logic            reset_i;
`ifdef EXEC_ARB_FLUSH_EN
  logic            flush_i;
`endif
  logic [NU-1:0]   unitValid_i;
  logic [NU*64-1:0] unitVal_i;
  logic [NU*10-1:0] unitCommands_i;
  logic [NU*TW-1:0] unitTag_i;
  logic [NU*4-1:0]  unitFlags_i;
  logic [NU-1:0]   canGo_o;
  logic            cdbStall_i;
  logic            cdbValid_o;
  logic [63:0]     cdbVal_o;
  logic [9:0]      cdbCommands_o;
  logic [TW-1:0]   cdbTag_o;
  logic [3:0]      cdbFlags_o;
  logic [1:0]      cdbSrc_o;

  always #5 clk = ~clk;

  exec_result_arbiter dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
`ifdef EXEC_ARB_FLUSH_EN
    .flush_i        (flush_i),
`endif
    .unitValid_i    (unitValid_i),
    .unitVal_i      (unitVal_i),
    .unitCommands_i (unitCommands_i),
    .unitTag_i      (unitTag_i),
    .unitFlags_i    (unitFlags_i),
    .canGo_o        (canGo_o),
    .cdbStall_i     (cdbStall_i),
    .cdbValid_o     (cdbValid_o),
    .cdbVal_o       (cdbVal_o),
    .cdbCommands_o  (cdbCommands_o),
    .cdbTag_o       (cdbTag_o),
    .cdbFlags_o     (cdbFlags_o),
    .cdbSrc_o       (cdbSrc_o)
  );

  typedef struct {
    logic [63:0]   val;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
    logic [3:0]    flags;
    logic [1:0]    src;
  } exp_t;

  exp_t          sb[$];
  logic [63:0]   u_val   [NU];
  logic [9:0]    u_cmd   [NU];
  logic [TW-1:0] u_tag   [NU];
  logic [3:0]    u_flags [NU];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NU; i++) begin
      unitVal_i[i*64 +: 64]      = u_val[i];
      unitCommands_i[i*10 +: 10] = u_cmd[i];
      unitTag_i[i*TW +: TW]      = u_tag[i];
      unitFlags_i[i*4 +: 4]      = u_flags[i];
    end
  endtask

  // Entered just after a posedge; checks grant late in the cycle, then the CDB after the next edge.
  task automatic step(input logic [NU-1:0] exp_gnt);
    exp_t e;
    #3;
    chk("canGo", canGo_o, exp_gnt);
    if (exp_gnt != '0) begin
      for (int k = 0; k < NU; k++) begin
        if (exp_gnt[k]) begin
          e.val = u_val[k]; e.cmd = u_cmd[k]; e.tag = u_tag[k];
          e.flags = u_flags[k]; e.src = 2'(k);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cdbValid", cdbValid_o, 1'b1);
      chk("cdbVal", cdbVal_o, e.val);
      chk("cdbCommands", cdbCommands_o, e.cmd);
      chk("cdbTag", cdbTag_o, e.tag);
      chk("cdbFlags", cdbFlags_o, e.flags);
      chk("cdbSrc", cdbSrc_o, e.src);
    end
  endtask

  initial begin
    for (int i = 0; i < NU; i++) begin
      u_val[i]   = 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h1111;
      u_cmd[i]   = 10'h3A0 + 10'(i);
      u_tag[i]   = TW'(i + 10);
      u_flags[i] = 4'hF - 4'(i);
    end
    u_val[2] = 64'h1234;
    u_tag[2] = 6'd5;
    u_tag[3] = 6'd7;
    apply();
    reset_i     = 1'b1;
    cdbStall_i  = 1'b0;
    unitValid_i = 4'b1111;
`ifdef EXEC_ARB_FLUSH_EN
    flush_i     = 1'b0;
`endif
    #2;
    chk("rst_canGo", canGo_o, 4'b0000);
    chk("rst_cdbValid", cdbValid_o, 1'b0);
    chk("rst_cdbVal", cdbVal_o, 64'h0);
    chk("rst_cdbTag", cdbTag_o, 6'h0);
    chk("rst_cdbSrc", cdbSrc_o, 2'h0);
    @(negedge clk);
    reset_i     = 1'b0;
    unitValid_i = 4'b0000;

    // Single request from unit 2; pointer moves to 3.
    unitValid_i = 4'b0100;
    step(4'b0100);
    // Pointer wrap: 3 first, then 0.
    unitValid_i = 4'b1001;
    step(4'b1000);
    step(4'b0001);
    unitValid_i = 4'b0000;
    step(4'b0000);
    chk("drain_valid", cdbValid_o, 1'b0);
    chk("drain_held_src", cdbSrc_o, 2'd0);

    // Async reset mid-cycle while the entry is valid (pointer now 1).
    unitValid_i = 4'b0010;
    step(4'b0010);
    reset_i     = 1'b1;
    #1;
    chk("arst_cdbValid", cdbValid_o, 1'b0);
    chk("arst_cdbVal", cdbVal_o, 64'h0);
    unitValid_i = 4'b1111;
    #1;
    chk("arst_canGo", canGo_o, 4'b0000);
    @(negedge clk);
    reset_i = 1'b0;

    // All units continuously valid: fair rotation, back-to-back broadcasts.
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);

    // Stall with tag 7 held on the CDB (pointer 1 -> grant unit 3).
    unitValid_i = 4'b1000;
    step(4'b1000);
    cdbStall_i  = 1'b1;
    unitValid_i = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("stall_canGo", canGo_o, 4'b0000);
      chk("stall_tag", cdbTag_o, 6'd7);
      chk("stall_valid", cdbValid_o, 1'b1);
      @(posedge clk);
      #1;
    end
    cdbStall_i = 1'b0;
    step(4'b0010);

`ifdef EXEC_ARB_FLUSH_EN
    flush_i = 1'b1;
    #3;
    chk("flush_canGo", canGo_o, 4'b0000);
    @(posedge clk);
    #1;
    chk("flush_valid", cdbValid_o, 1'b0);
    flush_i = 1'b0;
    step(4'b0010);
`endif

    unitValid_i = 4'b0000;
    step(4'b0000);
    chk("final_valid", cdbValid_o, 1'b0);
    chk("final_held_tag", cdbTag_o, u_tag[1]);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
